// File: rtl/clk_gen_pkg.sv
// rtl/clk_gen_pkg.sv - shared types and default widths for the clock generator
package clk_gen_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int EDGE_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } state_t;

endpackage

// File: rtl/clk_gen_phase_cnt.sv
// rtl/clk_gen_phase_cnt.sv - loadable half-period down-counter and clk_out toggle flop
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   start         force clk_out high next cycle and load start_h-1
//   start_h       half period used by start
//   run           counting enabled (block is not idle)
//   halt          force clk_out low and clear the counter next cycle
//   reload_h      half period loaded on every toggle
//   clk_out       registered generated clock
//   toggle        current cycle is the last of the phase
import clk_gen_pkg::*;

module clk_gen_phase_cnt #(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] start_h,
    input  logic             run,
    input  logic             halt,
    input  logic [CNT_W-1:0] reload_h,
    output logic             clk_out,
    output logic             toggle
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;

    // start_h and reload_h are never 0 when used, so H-1 cannot wrap.
    always_comb begin
        toggle = run && (cnt_q == '0);
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        if (halt) begin
            cnt_d = '0;
            clk_d = 1'b0;
        end else if (start) begin
            cnt_d = start_h - ONE;
            clk_d = 1'b1;
        end else if (toggle) begin
            cnt_d = reload_h - ONE;
            clk_d = ~clk_q;
        end else if (run) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end

    assign clk_out = clk_q;

endmodule

// File: rtl/clk_gen_ctrl.sv
// rtl/clk_gen_ctrl.sv - programmable 50% duty clock generator with glitch-free reconfiguration
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   cfg_valid/ready   configuration handshake
//   cfg_enable        1 = run, 0 = stop
//   cfg_half_period   clk_out half period in clk cycles (0 is illegal)
//   clk_out           generated clock
//   rise_tick         pulse in the first high cycle of clk_out
//   busy              generator active (RUN or STOP_PEND)
//   err               sticky illegal-configuration flag
//   edge_cnt          saturating count of clk_out rising edges
import clk_gen_pkg::*;

module clk_gen_ctrl #(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int EDGE_W = EDGE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              cfg_enable,
    input  logic [CNT_W-1:0]  cfg_half_period,
    output logic              clk_out,
    output logic              rise_tick,
    output logic              busy,
    output logic              err,
    output logic [EDGE_W-1:0] edge_cnt
);

    localparam logic [EDGE_W-1:0] EDGE_ONE = EDGE_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   h_q, h_d;
    logic               pend_v_q, pend_v_d;
    logic [CNT_W-1:0]   pend_h_q, pend_h_d;
    logic               rise_q, rise_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;
    logic [EDGE_W-1:0]  edge_q, edge_d;

    logic               hs, cfg_go, cfg_bad, cfg_stop;
    logic               pc_start, pc_run, pc_halt, pc_toggle, pc_clk;
    logic [CNT_W-1:0]   reload_h;

    assign hs       = cfg_valid && ready_q;
    assign cfg_go   = hs && cfg_enable && (cfg_half_period != '0);
    assign cfg_bad  = hs && cfg_enable && (cfg_half_period == '0);
    assign cfg_stop = hs && !cfg_enable;

    // A pending period is only adopted when the toggle is a low->high one,
    // so the high phase that follows is the first full phase at the new H.
    assign reload_h = (!pc_clk && pend_v_q) ? pend_h_q : h_q;
    assign pc_run   = (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        pend_v_d = pend_v_q;
        pend_h_d = pend_h_q;
        rise_d   = 1'b0;
        pc_start = 1'b0;
        pc_halt  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_go) begin
                    pc_start = 1'b1;
                    h_d      = cfg_half_period;
                    rise_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (pc_toggle && !pc_clk) begin
                    rise_d = 1'b1;
                    if (pend_v_q) begin
                        h_d      = pend_h_q;
                        pend_v_d = 1'b0;
                    end
                end
                // Captured after any adoption above, so a handshake on a rise
                // edge waits for the following rise.
                if (cfg_go) begin
                    pend_v_d = 1'b1;
                    pend_h_d = cfg_half_period;
                end else if (cfg_stop) begin
                    pend_v_d = 1'b0;
                    state_d  = STOP_PEND;
                end
            end
            STOP_PEND: begin
                // End of a high phase falls naturally; end of a low phase
                // would rise, which halt suppresses.
                if (pc_toggle) begin
                    pc_halt = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        err_d   = err_q | cfg_bad;
        edge_d  = (rise_d && (edge_q != '1)) ? edge_q + EDGE_ONE : edge_q;
        busy_d  = (state_d != IDLE);
        ready_d = (state_d != STOP_PEND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            h_q      <= '0;
            pend_v_q <= 1'b0;
            pend_h_q <= '0;
            rise_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            edge_q   <= '0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            pend_v_q <= pend_v_d;
            pend_h_q <= pend_h_d;
            rise_q   <= rise_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            edge_q   <= edge_d;
        end
    end

    clk_gen_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .start    (pc_start),
        .start_h  (cfg_half_period),
        .run      (pc_run),
        .halt     (pc_halt),
        .reload_h (reload_h),
        .clk_out  (pc_clk),
        .toggle   (pc_toggle)
    );

    assign cfg_ready = ready_q;
    assign clk_out   = pc_clk;
    assign rise_tick = rise_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign edge_cnt  = edge_q;

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// tb/tb_clk_gen_ctrl.sv - self-checking bench for clk_gen_ctrl
module tb_clk_gen_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_enable = 1'b0;
    logic [15:0] cfg_half_period = '0;
    logic        cfg_ready, clk_out, rise_tick, busy, err;
    logic [31:0] edge_cnt;
    logic        ready3, clk3, rise3, busy3, err3;
    logic [2:0]  edge3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    clk_gen_ctrl dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_enable(cfg_enable), .cfg_half_period(cfg_half_period),
        .clk_out(clk_out), .rise_tick(rise_tick), .busy(busy), .err(err),
        .edge_cnt(edge_cnt)
    );

    clk_gen_ctrl #(.EDGE_W(3)) dut3 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(ready3),
        .cfg_enable(cfg_enable), .cfg_half_period(cfg_half_period),
        .clk_out(clk3), .rise_tick(rise3), .busy(busy3), .err(err3),
        .edge_cnt(edge3)
    );

    function automatic void chk(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endfunction

    // Model: mode 0=idle 1=run 2=stopping; left = cycles remaining in the
    // current phase including the present one.
    int     m_mode = 0, m_level = 0, m_left = 0, m_h = 0, m_pv = 0, m_ph = 0;
    int     m_rise = 0, m_err = 0, m_ready = 0, m_on = 0;
    longint m_cnt = 0;

    always @(posedge clk) begin : model
        int mode, level, left, h, pv, ph, rise, er, ready;
        longint cnt;
        bit hs;
        mode = m_mode; level = m_level; left = m_left; h = m_h;
        pv = m_pv; ph = m_ph; er = m_err; cnt = m_cnt; rise = 0;
        if (rst) begin
            mode = 0; level = 0; left = 0; h = 0; pv = 0; ph = 0;
            er = 0; cnt = 0; ready = 0;
        end else begin
            hs = cfg_valid && (m_ready != 0);
            case (mode)
                0: if (hs && cfg_enable && cfg_half_period != 0) begin
                       mode = 1; level = 1; left = int'(cfg_half_period);
                       h = int'(cfg_half_period); rise = 1;
                   end
                1: begin
                       if (left > 1) left--;
                       else if (level == 1) begin level = 0; left = h; end
                       else begin
                           if (pv != 0) begin h = ph; pv = 0; end
                           level = 1; left = h; rise = 1;
                       end
                       if (hs && cfg_enable && cfg_half_period != 0) begin
                           pv = 1; ph = int'(cfg_half_period);
                       end else if (hs && !cfg_enable) begin
                           mode = 2; pv = 0;
                       end
                   end
                default: if (left > 1) left--; else begin mode = 0; level = 0; end
            endcase
            if (hs && cfg_enable && cfg_half_period == 0) er = 1;
            if (rise != 0) cnt++;
            ready = (mode != 2) ? 1 : 0;
        end
        m_mode <= mode; m_level <= level; m_left <= left; m_h <= h;
        m_pv <= pv; m_ph <= ph; m_rise <= rise; m_err <= er;
        m_cnt <= cnt; m_ready <= ready; m_on <= 1;
    end

    always @(negedge clk) begin
        if (m_on != 0) begin
            chk("clk_out", clk_out, m_level);
            chk("rise_tick", rise_tick, m_rise);
            chk("busy", busy, (m_mode != 0) ? 1 : 0);
            chk("err", err, m_err);
            chk("cfg_ready", cfg_ready, m_ready);
            chk("edge_cnt", edge_cnt, m_cnt & 64'hFFFF_FFFF);
            chk("edge_cnt_w3", edge3, (m_cnt > 7) ? 7 : m_cnt);
        end
    end

    // Called at a negedge; returns at the negedge of the first cycle after the handshake edge.
    task automatic hs_cfg(input logic en, input logic [15:0] h);
        cfg_valid = 1'b1;
        cfg_enable = en;
        cfg_half_period = h;
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_enable = 1'b0;
        cfg_half_period = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int hi, rs;
        repeat (3) @(negedge clk);
        chk("rst_ready", cfg_ready, 0);
        chk("rst_clk", clk_out, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", cfg_ready, 1);

        // H=5: period 10, 5 high, 2 rises in 20 cycles, 3rd rise at cycle 21
        hs_cfg(1'b1, 16'd5);
        hi = 0; rs = 0;
        for (int i = 0; i < 20; i++) begin
            hi += int'(clk_out); rs += int'(rise_tick);
            @(negedge clk);
        end
        chk("h5_high_cycles", hi, 10);
        chk("h5_rises", rs, 2);
        chk("h5_edge_cnt", edge_cnt, 3);
        hs_cfg(1'b0, 16'd0);
        wait_idle();

        // H=1: clk/2
        hs_cfg(1'b1, 16'd1);
        for (int i = 0; i < 8; i++) begin
            chk("h1_clk", clk_out, (i % 2 == 0) ? 1 : 0);
            chk("h1_rise", rise_tick, (i % 2 == 0) ? 1 : 0);
            @(negedge clk);
        end
        hs_cfg(1'b0, 16'd0);
        wait_idle();

        // H=4 then H=2 mid high phase, then back-to-back 6 and 3
        hs_cfg(1'b1, 16'd4);          // cycle 1
        @(negedge clk);               // cycle 2
        hs_cfg(1'b1, 16'd2);          // cycle 3
        repeat (5) @(negedge clk);    // cycle 8
        chk("upd_c8_low", clk_out, 0);
        @(negedge clk);               // cycle 9
        chk("upd_c9_rise", rise_tick, 1);
        repeat (3) @(negedge clk);    // cycle 12
        chk("upd_c12_low", clk_out, 0);
        @(negedge clk);               // cycle 13
        chk("upd_c13_rise", rise_tick, 1);
        hs_cfg(1'b1, 16'd6);          // cycle 14
        hs_cfg(1'b1, 16'd3);          // cycle 15
        repeat (2) @(negedge clk);    // cycle 17
        chk("upd_c17_rise", rise_tick, 1);
        repeat (2) @(negedge clk);    // cycle 19
        chk("upd_c19_high", clk_out, 1);
        @(negedge clk);               // cycle 20
        chk("upd_c20_low", clk_out, 0);
        repeat (3) @(negedge clk);    // cycle 23
        chk("upd_c23_rise", rise_tick, 1);
        hs_cfg(1'b0, 16'd0);
        wait_idle();

        // Stop one cycle into a high phase at H=4
        hs_cfg(1'b1, 16'd4);          // cycle 1
        hs_cfg(1'b0, 16'd0);          // cycle 2
        for (int i = 0; i < 3; i++) begin
            chk("stop_high", clk_out, 1);
            chk("stop_ready", cfg_ready, 0);
            chk("stop_busy", busy, 1);
            @(negedge clk);
        end
        chk("stop_low", clk_out, 0);
        chk("stop_busy_fall", busy, 0);
        chk("stop_ready_back", cfg_ready, 1);
        repeat (2) @(negedge clk);

        // Illegal H=0 in IDLE and in RUN
        hs_cfg(1'b1, 16'd0);
        chk("err_idle", err, 1);
        chk("err_idle_clk", clk_out, 0);
        chk("err_idle_busy", busy, 0);
        hs_cfg(1'b1, 16'd3);
        repeat (3) @(negedge clk);
        hs_cfg(1'b1, 16'd0);
        repeat (6) @(negedge clk);
        chk("err_run_sticky", err, 1);
        hs_cfg(1'b0, 16'd0);
        wait_idle();
        chk("err_still", err, 1);

        // Reset clears err; run H=1 to edge_cnt 7 then 10, reset mid-run
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("err_cleared", err, 0);
        rst = 1'b0;
        @(negedge clk);
        hs_cfg(1'b1, 16'd1);          // cycle 1
        repeat (12) @(negedge clk);   // cycle 13
        chk("edge7", edge_cnt, 7);
        repeat (6) @(negedge clk);    // cycle 19
        chk("edge10", edge_cnt, 10);
        chk("edge_w3_sat", edge3, 7);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_clk", clk_out, 0);
        chk("rst_mid_edge", edge_cnt, 0);
        chk("rst_mid_busy", busy, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_gen_ctrl.md
CLK_GEN_CTRL -- requirements
Module: clk_gen_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the half-period count.
REQ-002 Parameter EDGE_W, default 32: width of the rising-edge counter.
REQ-003 The block SHALL have these ports, one per line:
  clk  input  1  single system clock; all logic on its rising edge.
  rst  input  1  synchronous, active-high reset.
  cfg_valid  input  1  configuration request.
  cfg_ready  output  1  block accepts configuration this cycle.
  cfg_enable  input  1  1 = run, 0 = stop.
  cfg_half_period  input  CNT_W  clk_out half-period in clk cycles; 0 is illegal.
  clk_out  output  1  generated clock, 50% duty, registered.
  rise_tick  output  1  one-cycle pulse in the first cycle clk_out is high.
  busy  output  1  high in RUN or STOP_PEND.
  err  output  1  sticky flag for an illegal configuration.
  edge_cnt  output  EDGE_W  count of clk_out rising edges, saturating.

Function
REQ-004 A handshake SHALL occur only when cfg_valid and cfg_ready are both high at a clk edge; the fields are sampled at that edge.
REQ-005 The FSM SHALL have three states: IDLE, RUN and STOP_PEND.
REQ-006 cfg_ready SHALL be 1 in IDLE and RUN, and 0 in STOP_PEND.
REQ-007 In IDLE, clk_out SHALL be 0.
REQ-008 IDLE: a handshake with cfg_enable=1 and H=cfg_half_period!=0 SHALL do all of the following:
  - load H;
  - drive clk_out=1 and rise_tick=1 in the next cycle;
  - enter RUN.
REQ-009 RUN: clk_out SHALL toggle every H clk cycles, giving a period of 2H cycles; H=1 gives clk/2.
REQ-010 rise_tick SHALL be high for exactly the first cycle of every clk_out high phase, and 0 otherwise.
REQ-011 RUN: a handshake with cfg_enable=1 and H!=0 SHALL be held as pending and take effect at the next clk_out rising transition, so no runt phase occurs.
REQ-012 A later pending handshake SHALL overwrite an earlier one (last wins).
REQ-013 RUN: a handshake with cfg_enable=0 SHALL enter STOP_PEND and discard any pending configuration.
REQ-014 STOP_PEND: clk_out SHALL complete its current phase.
  - If high, the current high phase completes, then clk_out goes low and the FSM enters IDLE.
  - If low, the FSM enters IDLE at the point the next rise would occur, and no rise occurs.
REQ-015 A handshake with cfg_enable=1 and H=0, in any state, SHALL set err and otherwise change nothing.
REQ-016 IDLE: a handshake with cfg_enable=0 SHALL be accepted as a no-op.
REQ-017 edge_cnt SHALL increment on each cycle where rise_tick=1, and SHALL saturate at all-ones.
REQ-018 busy SHALL equal (state != IDLE).
REQ-019 The internal phase counter SHALL count down from H-1 to 0 and reload on each toggle; it SHALL never wrap.

Reset
REQ-020 While rst=1 at a clk edge, the block SHALL set:
  - state=IDLE;
  - clk_out=0, rise_tick=0, busy=0, err=0;
  - edge_cnt=0;
  - cfg_ready=0, and 1 in the cycle after rst deasserts;
  - pending configuration cleared.
REQ-021 Reset asserted mid-RUN SHALL force clk_out=0 in the following cycle, with no partial phase completing afterwards.
REQ-022 err SHALL clear only on reset.

Structure
REQ-023 A shared package clk_gen_pkg SHALL hold the state enum type (IDLE, RUN, STOP_PEND) and the default CNT_W and EDGE_W constants.
REQ-024 One sub-module, clk_gen_phase_cnt, SHALL hold the loadable down-counter and toggle generation; the FSM, handshake, pending register and edge counter stay in clk_gen_ctrl.
REQ-025 All outputs SHALL be driven directly from flops; there are no combinational paths from input to output except cfg_ready, which derives from state only.

Verification
REQ-026 Reset, then a handshake with enable=1, H=5 -> clk_out period 10 cycles, high 5 and low 5; rise_tick high once per 10 cycles; edge_cnt=3 after three rises.
REQ-027 H=1 -> clk_out toggles every cycle, matching clk/2 (20 ns period at 100 MHz clk); rise_tick high every other cycle.
REQ-028 Running at H=4, then a handshake with H=2 in mid high phase -> the current period stays at 8 cycles and new periods are 4 cycles from the next rise; two back-to-back updates (H=2, then H=3) -> H=3 applies.
REQ-029 Stop handshake 1 cycle into a high phase at H=4 -> clk_out stays high 3 more cycles, then 0; busy falls the same cycle; cfg_ready is 0 during STOP_PEND.
REQ-030 A handshake with enable=1, H=0 in IDLE, then in RUN -> err=1 and stays 1; clk_out behaviour is unchanged; err clears only after rst.
REQ-031 rst asserted mid-RUN with edge_cnt=7 -> next cycle clk_out=0, edge_cnt=0, state IDLE; with EDGE_W=3 forced, edge_cnt saturates at 7.
